// File: rtl/mips_alu_pkg.sv
// rtl/mips_alu_pkg.sv - shared control codes and FSM states for the sequential MIPS ALU
package mips_alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SLTU  = 4'b0011;
    localparam logic [3:0] ALU_MULTU = 4'b0100;
    localparam logic [3:0] ALU_MULT  = 4'b0101;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_DIVU  = 4'b1000;
    localparam logic [3:0] ALU_DIV   = 4'b1001;
    localparam logic [3:0] ALU_MFHI  = 4'b1010;
    localparam logic [3:0] ALU_MFLO  = 4'b1011;
    localparam logic [3:0] ALU_NOR   = 4'b1100;
    localparam logic [3:0] ALU_XOR   = 4'b1101;
    localparam logic [3:0] ALU_EQ    = 4'b1110;
    localparam logic [3:0] ALU_RSVD  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } alu_state_t;

    function automatic logic is_muldiv(input logic [3:0] ctrl);
        return (ctrl == ALU_MULTU) || (ctrl == ALU_MULT) ||
               (ctrl == ALU_DIVU)  || (ctrl == ALU_DIV);
    endfunction

    function automatic logic is_div(input logic [3:0] ctrl);
        return (ctrl == ALU_DIVU) || (ctrl == ALU_DIV);
    endfunction

    function automatic logic is_signed_md(input logic [3:0] ctrl);
        return (ctrl == ALU_MULT) || (ctrl == ALU_DIV);
    endfunction

endpackage

// File: rtl/mips_muldiv_iter.sv
// rtl/mips_muldiv_iter.sv - unsigned iterative engine: shift-add multiply, restoring divide
module mips_muldiv_iter
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             valid_o
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    logic [WIDTH-1:0] hi_q, lo_q, b_q;
    logic [CNT_W-1:0] cnt_q;
    logic             run_q, div_q, valid_q;

    logic [WIDTH:0]   add_sum, rem_shift, rem_diff;
    logic [WIDTH-1:0] hi_d, lo_d;

    // hi holds the partial product / running remainder, lo the multiplier / quotient
    always_comb begin
        add_sum   = {1'b0, hi_q} + {1'b0, b_q};
        rem_shift = {hi_q, lo_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, b_q};
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (div_q) begin
            if (!rem_diff[WIDTH]) begin
                hi_d = rem_diff[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = rem_shift[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else if (lo_q[0]) begin
            {hi_d, lo_d} = {add_sum, lo_q[WIDTH-1:1]};
        end else begin
            {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            div_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (start_i) begin
                hi_q  <= '0;
                lo_q  <= a_i;
                b_q   <= b_i;
                div_q <= div_i;
                cnt_q <= CNT_FULL;
                run_q <= 1'b1;
            end else if (run_q) begin
                hi_q  <= hi_d;
                lo_q  <= lo_d;
                cnt_q <= cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    run_q   <= 1'b0;
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/mips_alu_seq.sv
// rtl/mips_alu_seq.sv - registered MIPS ALU with iterative mult/div, HI/LO and Start/Busy/Done
module mips_alu_seq
    import mips_alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [3:0]       Control,
    input  logic [WIDTH-1:0] Data1,
    input  logic [WIDTH-1:0] Data2,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Output,
    output logic             Zero,
    output logic             Overflow,
    output logic             DivZero
);

    alu_state_t       state_q;
    logic             busy_q, done_q, zero_q, ovf_q, dz_q;
    logic [WIDTH-1:0] out_q, hi_q, lo_q, a_raw_q;
    logic             md_div_q, neg_lo_q, neg_hi_q, dz_pend_q;

    logic             accept, op_md, op_div, op_signed, div_by_zero, eng_start;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] eng_hi, eng_lo;
    logic             eng_valid;

    logic [WIDTH-1:0]   sum_d, diff_d, res_d;
    logic               ovf_d;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix, fix_hi, fix_lo;

    assign accept      = Start && !busy_q;
    assign op_md       = is_muldiv(Control);
    assign op_div      = is_div(Control);
    assign op_signed   = is_signed_md(Control);
    assign div_by_zero = op_div && (Data2 == '0);
    assign eng_start   = accept && op_md && !div_by_zero;

    // The engine is unsigned; signed ops feed it magnitudes and fix the signs in FIX.
    assign a_neg = op_signed && Data1[WIDTH-1];
    assign b_neg = op_signed && Data2[WIDTH-1];
    assign a_mag = a_neg ? -Data1 : Data1;
    assign b_mag = b_neg ? -Data2 : Data2;

    mips_muldiv_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (eng_start),
        .div_i   (op_div),
        .a_i     (a_mag),
        .b_i     (b_mag),
        .hi_o    (eng_hi),
        .lo_o    (eng_lo),
        .valid_o (eng_valid)
    );

    always_comb begin
        sum_d  = Data1 + Data2;
        diff_d = Data1 - Data2;
        res_d  = '0;
        ovf_d  = 1'b0;
        case (Control)
            ALU_AND:  res_d = Data1 & Data2;
            ALU_OR:   res_d = Data1 | Data2;
            ALU_ADD: begin
                res_d = sum_d;
                ovf_d = (Data1[WIDTH-1] == Data2[WIDTH-1]) && (sum_d[WIDTH-1] != Data1[WIDTH-1]);
            end
            ALU_SUB: begin
                res_d = diff_d;
                ovf_d = (Data1[WIDTH-1] != Data2[WIDTH-1]) && (diff_d[WIDTH-1] != Data1[WIDTH-1]);
            end
            ALU_EQ:   res_d = {{(WIDTH-1){1'b0}}, (Data1 == Data2)};
            ALU_SLT:  res_d = {{(WIDTH-1){1'b0}}, ($signed(Data1) < $signed(Data2))};
            ALU_SLTU: res_d = {{(WIDTH-1){1'b0}}, (Data1 < Data2)};
            ALU_NOR:  res_d = ~(Data1 | Data2);
            ALU_XOR:  res_d = Data1 ^ Data2;
            ALU_MFHI: res_d = hi_q;
            ALU_MFLO: res_d = lo_q;
            default:  res_d = '0;
        endcase
    end

    // Remainder follows the dividend's sign; quotient and product follow sign(A)^sign(B).
    always_comb begin
        prod_fix = neg_lo_q ? -{eng_hi, eng_lo} : {eng_hi, eng_lo};
        q_fix    = neg_lo_q ? -eng_lo : eng_lo;
        r_fix    = neg_hi_q ? -eng_hi : eng_hi;
        if (dz_pend_q) begin
            fix_hi = a_raw_q;
            fix_lo = '1;
        end else if (md_div_q) begin
            fix_hi = r_fix;
            fix_lo = q_fix;
        end else begin
            {fix_hi, fix_lo} = prod_fix;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            out_q     <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            a_raw_q   <= '0;
            md_div_q  <= 1'b0;
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
            dz_pend_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        dz_q <= 1'b0;
                        if (op_md) begin
                            busy_q    <= 1'b1;
                            ovf_q     <= 1'b0;
                            md_div_q  <= op_div;
                            neg_lo_q  <= a_neg ^ b_neg;
                            neg_hi_q  <= a_neg;
                            dz_pend_q <= div_by_zero;
                            a_raw_q   <= Data1;
                            state_q   <= div_by_zero ? ST_FIX : ST_RUN;
                        end else begin
                            out_q  <= res_d;
                            zero_q <= (res_d == '0);
                            ovf_q  <= ovf_d;
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (eng_valid) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                    out_q   <= fix_lo;
                    zero_q  <= (fix_lo == '0);
                    dz_q    <= dz_pend_q;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Output   = out_q;
    assign Zero     = zero_q;
    assign Overflow = ovf_q;
    assign DivZero  = dz_q;

endmodule

// File: tb/tb_mips_alu_seq.sv
// tb/tb_mips_alu_seq.sv - scoreboard bench for mips_alu_seq at WIDTH=32 and WIDTH=8
module tb_mips_alu_seq;
    import mips_alu_pkg::*;

    localparam logic [2:0] FZ = 3'b100;
    localparam logic [2:0] FO = 3'b010;
    localparam logic [2:0] FD = 3'b001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start;
    logic [3:0]  ctrl;
    logic [31:0] d1, d2, out;
    logic        busy, done, zero, ovf, dz;

    logic        start8;
    logic [3:0]  ctrl8;
    logic [7:0]  d1_8, d2_8, out8;
    logic        busy8, done8, zero8, ovf8, dz8;

    always #5 clk = ~clk;

    mips_alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .Start(start), .Control(ctrl), .Data1(d1), .Data2(d2),
        .Busy(busy), .Done(done), .Output(out), .Zero(zero), .Overflow(ovf), .DivZero(dz)
    );

    mips_alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .Start(start8), .Control(ctrl8), .Data1(d1_8), .Data2(d2_8),
        .Busy(busy8), .Done(done8), .Output(out8), .Zero(zero8), .Overflow(ovf8), .DivZero(dz8)
    );

    typedef struct {
        logic [31:0] out;
        logic [2:0]  flags;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] out;
        logic [2:0]  flags;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Every Done must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got Done=1 out=%0h want no Done", out);
            end else begin
                e = sb.pop_front();
                check("out", {32'd0, out}, {32'd0, e.out});
                check("flags_zod", {61'd0, zero, ovf, dz}, {61'd0, e.flags});
                check("latency", 64'(cyc - e.acc), 64'(e.lat));
            end
        end
    end

    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eo, input logic [2:0] ef, input int lat);
        exp_t e;
        e.out = eo; e.flags = ef; e.lat = lat; e.acc = cyc + 1;
        sb.push_back(e);
        start = 1'b1; ctrl = c; d1 = a; d2 = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drive_raw(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; ctrl = c; d1 = a; d2 = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: timeout pending=%0d busy=%b want pending=0 busy=0", name, sb.size(), busy);
        end
    endtask

    task automatic muldiv(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lo, input logic [31:0] hi, input logic [2:0] ef,
                          input int lat, input string name);
        issue(c, a, b, lo, ef, lat);
        wait_idle(name);
        issue(ALU_MFHI, 32'h0, 32'h0, hi, (hi == 32'h0) ? FZ : 3'b000, 0);
        wait_idle({name, "_mfhi"});
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int acc8;
        start = 0; ctrl = 0; d1 = 0; d2 = 0;
        start8 = 0; ctrl8 = 0; d1_8 = 0; d2_8 = 0;

        tbl.push_back('{ALU_MFHI, 32'h0,        32'h0,        32'h0,        FZ});
        tbl.push_back('{ALU_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 3'b000});
        tbl.push_back('{ALU_OR,   32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 3'b000});
        tbl.push_back('{ALU_ADD,  32'h7FFFFFFF, 32'h1,        32'h80000000, FO});
        tbl.push_back('{ALU_ADD,  32'hFFFFFFFF, 32'h1,        32'h0,        FZ});
        tbl.push_back('{ALU_ADD,  32'h80000000, 32'h80000000, 32'h0,        FZ | FO});
        tbl.push_back('{ALU_SUB,  32'h5,        32'h5,        32'h0,        FZ});
        tbl.push_back('{ALU_SUB,  32'h80000000, 32'h1,        32'h7FFFFFFF, FO});
        tbl.push_back('{ALU_SUB,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, FO});
        tbl.push_back('{ALU_EQ,   32'h7,        32'h7,        32'h1,        3'b000});
        tbl.push_back('{ALU_EQ,   32'h7,        32'h8,        32'h0,        FZ});
        tbl.push_back('{ALU_SLT,  32'hFFFFFFFF, 32'h1,        32'h1,        3'b000});
        tbl.push_back('{ALU_SLTU, 32'hFFFFFFFF, 32'h1,        32'h0,        FZ});
        tbl.push_back('{ALU_NOR,  32'h0,        32'h0,        32'hFFFFFFFF, 3'b000});
        tbl.push_back('{ALU_XOR,  32'hA5A5A5A5, 32'hFFFF0000, 32'h5A5AA5A5, 3'b000});
        tbl.push_back('{ALU_RSVD, 32'h3,        32'h4,        32'h0,        FZ});

        repeat (2) @(posedge clk);
        #1;
        check("reset_outs32", {26'd0, out, zero, ovf, dz, busy, done}, 64'd0);
        check("reset_outs8", {50'd0, out8, zero8, ovf8, dz8, busy8, done8}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back single-cycle ops, one Start per cycle.
        foreach (tbl[i]) issue(tbl[i].ctrl, tbl[i].a, tbl[i].b, tbl[i].out, tbl[i].flags, 0);
        wait_idle("table");

        // MULT -3 x 7 with Start pulses while busy that must be ignored.
        issue(ALU_MULT, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFEB, 3'b000, 34);
        for (int k = 0; k < 6; k++) begin
            check("busy_during_mult", {63'd0, busy}, 64'd1);
            drive_raw((k == 3) ? ALU_DIVU : ALU_ADD, 32'(k), 32'h0);
        end
        wait_idle("mult_neg3x7");
        issue(ALU_MFLO, 32'h0, 32'h0, 32'hFFFFFFEB, 3'b000, 0);
        issue(ALU_MFHI, 32'h0, 32'h0, 32'hFFFFFFFF, 3'b000, 0);
        wait_idle("mult_readback");

        muldiv(ALU_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 32'hFFFFFFFF, 3'b000, 34, "div_neg7_2");
        muldiv(ALU_DIVU,  32'd100,      32'h0,        32'hFFFFFFFF, 32'd100,      FD,     1,  "divu_by0");
        muldiv(ALU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0,        3'b000, 34, "div_min_m1");
        muldiv(ALU_DIVU,  32'd100,      32'd7,        32'd14,       32'd2,        3'b000, 34, "divu_100_7");
        muldiv(ALU_DIV,   32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        3'b000, 34, "div_7_m2");
        muldiv(ALU_MULT,  32'h80000000, 32'h80000000, 32'h0,        32'h40000000, FZ,     34, "mult_min_min");
        muldiv(ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        32'hFFFFFFFE, 3'b000, 34, "multu_max");

        // Reset ten cycles into a DIV: nothing of it may survive.
        drive_raw(ALU_DIV, 32'h12345678, 32'h3);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_mid_div", {26'd0, out, zero, ovf, dz, busy, done}, 64'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(ALU_MFHI, 32'h0, 32'h0, 32'h0, FZ, 0);
        issue(ALU_MFLO, 32'h0, 32'h0, 32'h0, FZ, 0);
        wait_idle("after_reset");

        // WIDTH=8 instance: 0xFF x 0xFF.
        acc8 = cyc + 1;
        start8 = 1'b1; ctrl8 = ALU_MULTU; d1_8 = 8'hFF; d2_8 = 8'hFF;
        @(posedge clk); #1;
        start8 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done8) begin
                seen = 1'b1;
                break;
            end
        end
        check("w8_done_seen", {63'd0, seen}, 64'd1);
        check("w8_latency", 64'(cyc - acc8), 64'd10);
        check("w8_lo", {56'd0, out8}, 64'h01);
        check("w8_flags", {61'd0, zero8, ovf8, dz8}, 64'd0);
        @(posedge clk); #1;
        start8 = 1'b1; ctrl8 = ALU_MFHI;
        @(posedge clk); #1;
        start8 = 1'b0;
        @(negedge clk);
        check("w8_mfhi_done", {63'd0, done8}, 64'd1);
        check("w8_hi", {56'd0, out8}, 64'hFE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_alu_seq.md
Name: mips_alu_seq

Overview:
Parametrised, registered successor to the single-cycle MIPS ALU.
- Keeps the existing 4-bit Control encoding for the logical and arithmetic ops, with 1-cycle registered latency.
- Adds SLTU, signed/unsigned iterative multiply and divide into internal HI/LO registers, MFHI/MFLO, a real overflow flag, and a Start/Busy/Done handshake.
- Sits in the EX stage; the pipeline stalls while Busy is high.

Parameters:
WIDTH, 32, operand/result width in bits (>=4).
CNT_W, $clog2(WIDTH)+1, width of the iteration counter (derived; do not override).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
Start  in  1  request; sampled on a rising edge only when Busy=0.
Control  in  4  operation select, captured with Start.
Data1  in  WIDTH  operand A, captured with Start.
Data2  in  WIDTH  operand B, captured with Start.
Busy  out  1  multi-cycle op in progress; Start is ignored while high.
Done  out  1  one-cycle pulse: Output and flags are valid.
Output  out  WIDTH  registered result; held until the next accepted op.
Zero  out  1  registered; (Output==0), updated with Output.
Overflow  out  1  signed overflow of ADD/SUB; 0 for all other ops.
DivZero  out  1  set when DIV/DIVU has Data2==0; cleared by the next accepted op.

Behaviour:
Reset:
- Output, Hi, Lo, Zero, Overflow, DivZero, Busy and Done all go to 0; FSM goes to IDLE.
- Reset is asynchronous and may abort any operation; no partial Hi/Lo update survives it.

Encoding (Control -> op):
- 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 1110 EQ (Output = (A==B)); 0111 SLT (signed); 0011 SLTU; 1100 NOR; 1101 XOR.
- 1010 MFHI; 1011 MFLO; 0100 MULTU; 0101 MULT; 1000 DIVU; 1001 DIV.
- 1111 is reserved: Output=0 with 1-cycle latency.

Single-cycle ops (all except mult/div):
- Result is registered at the accepting edge; Done=1 in the next cycle.
- Busy stays 0, so back-to-back Start on every cycle is legal.
- ADD/SUB are modular; Overflow = signed overflow (operand signs equal and result sign differs; for SUB, use ~B's sign).
- MFHI/MFLO return Hi/Lo as they stand at the accepting edge.

FSM for mult/div: IDLE -> RUN -> FIX -> IDLE.
- Accepting edge: capture operand magnitudes (absolute values for signed ops), record result signs, counter=WIDTH, Busy=1.
- RUN: WIDTH iterations, one bit per cycle.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring division.
- FIX: apply two's-complement sign correction, write Hi/Lo, set Output=Lo, Busy=0.
- Done=1 in the cycle after FIX, i.e. WIDTH+2 edges after the accepting edge (34 at WIDTH=32).
- Signed multiply: 2*WIDTH product, exact for all inputs including MIN*MIN.
- Signed divide: quotient truncates toward zero; remainder takes the sign of the dividend.
- MIN / -1: Lo=MIN, Hi=0, no flag.
- Divide by zero: skip RUN (go straight to FIX); Hi=Data1, Lo=all ones, DivZero=1.
- Start asserted while Busy=1: ignored entirely, no effect on state or flags.
- Hi/Lo are written only in FIX.

Decomposition:
- Shared package mips_alu_pkg holds:
  - localparams for all Control codes (ALU_AND ... ALU_DIV);
  - FSM state encodings (ST_IDLE, ST_RUN, ST_FIX).
- One sub-module, mips_muldiv_iter: the iterative engine. It receives magnitudes plus start, and returns hi/lo plus a valid pulse.
- mips_alu_seq owns the handshake, sign handling, the single-cycle datapath and the output registers.

Test Plan:
- Reset mid-DIV (rst_n low at RUN cycle 10) -> all outputs 0, Busy=0; a subsequent MFHI returns 0.
- ADD 0x7FFFFFFF+1 -> Output=0x80000000, Overflow=1, Done 1 cycle later. SUB 5-5 -> Output=0, Zero=1, Overflow=0.
- SLT 0xFFFFFFFF,1 -> 1. SLTU with the same operands -> 0. EQ 7,7 -> 1.
- MULT 0xFFFFFFFD(-3) x 7 -> Done at edge 34; Hi=0xFFFFFFFF, Lo=0xFFFFFFEB. MFLO -> 0xFFFFFFEB. Start pulses issued during Busy are ignored.
- DIV -7 / 2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU 100/0 -> DivZero=1, Hi=100, Lo=0xFFFFFFFF.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=1. Repeat with WIDTH=8: 0xFF x 0xFF -> Hi=0xFE, Lo=0x01, Done at edge 10.
